// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/result bundle between the execute stage and the ALU/MDU
// The master issues an operation with start; the slave returns a registered result and the busy/done handshake.
interface alu_mdu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  ALUResult, Zero, Overflow, busy, done
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output ALUResult, Zero, Overflow, busy, done
  );
endinterface

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU with iterative unsigned multiply/divide into HI/LO
// Single-cycle ops complete in one clock; MULTU/DIVU iterate one bit per cycle.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        reset,
  alu_mdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_NOR = 4'd2, OP_ADD = 4'd3,
                         OP_SUB = 4'd4, OP_LUI = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_SLT = 4'd8, OP_SRA = 4'd9, OP_MULTU = 4'd10, OP_DIVU = 4'd11,
                         OP_MFHI = 4'd12, OP_MFLO = 4'd13;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] res, res_n, hi, hi_n, lo, lo_n;
  logic [WIDTH-1:0] mcand, mcand_n, work, work_n, acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             zero, zero_n, ovf, ovf_n, done, done_n;

  logic [WIDTH-1:0] sum, diff, single_res;
  logic             single_ovf;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] mul_lo, div_rem, div_quo;

  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (bus.ALUOperation)
      OP_AND:  single_res = bus.A & bus.B;
      OP_OR:   single_res = bus.A | bus.B;
      OP_NOR:  single_res = ~(bus.A | bus.B);
      OP_ADD: begin
        single_res = sum;
        single_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = diff;
        single_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_LUI:  single_res = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  single_res = bus.B << bus.shamt;
      OP_SRL:  single_res = bus.B >> bus.shamt;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SRA:  single_res = $signed(bus.B) >>> bus.shamt;
      OP_MFHI: single_res = hi;
      OP_MFLO: single_res = lo;
      default: single_res = '0;
    endcase
  end

  // Shift-add keeps {acc, work} as the growing product; work shifts the multiplier out.
  assign mul_sum = {1'b0, acc} + (work[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_lo  = {mul_sum[0], work[WIDTH-1:1]};

  // Restoring division: work holds the dividend shifting out and the quotient shifting in.
  assign div_shift = {acc, work[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand};
  assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_quo   = {work[WIDTH-2:0], ~div_trial[WIDTH]};

  always_comb begin
    state_n = state;
    res_n   = res;
    zero_n  = zero;
    ovf_n   = ovf;
    hi_n    = hi;
    lo_n    = lo;
    mcand_n = mcand;
    work_n  = work;
    acc_n   = acc;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.ALUOperation == OP_MULTU || (bus.ALUOperation == OP_DIVU && bus.B != '0)) begin
            mcand_n = bus.B;
            work_n  = bus.A;
            acc_n   = '0;
            cnt_n   = CW'(WIDTH);
            state_n = (bus.ALUOperation == OP_MULTU) ? MUL : DIV;
          end else if (bus.ALUOperation == OP_DIVU) begin
            hi_n   = bus.A;
            lo_n   = '1;
            res_n  = '1;
            zero_n = 1'b0;
            ovf_n  = 1'b0;
            done_n = 1'b1;
          end else begin
            res_n  = single_res;
            zero_n = (single_res == '0);
            ovf_n  = single_ovf;
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n  = mul_sum[WIDTH:1];
        work_n = mul_lo;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = mul_sum[WIDTH:1];
          lo_n    = mul_lo;
          res_n   = mul_lo;
          zero_n  = (mul_lo == '0);
          ovf_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      DIV: begin
        acc_n  = div_rem;
        work_n = div_quo;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = div_rem;
          lo_n    = div_quo;
          res_n   = div_quo;
          zero_n  = (div_quo == '0);
          ovf_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      res   <= '0;
      zero  <= 1'b1;
      ovf   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      work  <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      res   <= res_n;
      zero  <= zero_n;
      ovf   <= ovf_n;
      hi    <= hi_n;
      lo    <= lo_n;
      mcand <= mcand_n;
      work  <= work_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  assign bus.ALUResult = res;
  assign bus.Zero      = zero;
  assign bus.Overflow  = ovf;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against an arithmetic reference model
// Directed cases pin known values; random traffic is checked every cycle against the model.
module tb_alu_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) io ();
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(io));

  logic [W-1:0] m_res, m_hi, m_lo, p_hi, p_lo;
  logic         m_zero, m_ovf, m_busy, m_done;
  int           left;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outcome of each request from plain arithmetic, multi-cycle ops as a countdown.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_res = '0; m_zero = 1'b1; m_ovf = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_hi = '0; m_lo = '0; left = 0;
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_hi = p_hi; m_lo = p_lo;
          m_res = p_lo; m_zero = (p_lo == 0); m_ovf = 1'b0;
          m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (io.start) begin
        logic [W-1:0] a, b, r;
        logic [2*W-1:0] prod;
        longint s;
        bit o;
        a = io.A; b = io.B; r = '0; o = 1'b0;
        case (io.ALUOperation)
          4'd0: r = a & b;
          4'd1: r = a | b;
          4'd2: r = ~(a | b);
          4'd3: begin
            s = longint'($signed(a)) + longint'($signed(b));
            r = W'(s);
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          end
          4'd4: begin
            s = longint'($signed(a)) - longint'($signed(b));
            r = W'(s);
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          end
          4'd5: r = (b % 32'h10000) * 32'h10000;
          4'd6: r = b << io.shamt;
          4'd7: r = b >> io.shamt;
          4'd8: r = ($signed(a) < $signed(b)) ? 1 : 0;
          4'd9: r = W'(longint'($signed(b)) / (64'sd1 << io.shamt) - ((b[W-1] && (b % (32'd1 << io.shamt)) != 0) ? 1 : 0));
          4'd12: r = m_hi;
          4'd13: r = m_lo;
          default: r = '0;
        endcase
        if (io.ALUOperation == 4'd10) begin
          prod = {32'd0, a} * {32'd0, b};
          p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0];
          left = W; m_busy = 1'b1;
        end else if (io.ALUOperation == 4'd11 && b != 0) begin
          p_hi = a % b; p_lo = a / b;
          left = W; m_busy = 1'b1;
        end else if (io.ALUOperation == 4'd11) begin
          m_hi = a; m_lo = '1;
          m_res = '1; m_zero = 1'b0; m_ovf = 1'b0; m_done = 1'b1;
        end else begin
          m_res = r; m_zero = (r == 0); m_ovf = o; m_done = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmp_result", io.ALUResult, m_res);
    chk("cmp_zero", W'(io.Zero), W'(m_zero));
    chk("cmp_ovf", W'(io.Overflow), W'(m_ovf));
    chk("cmp_busy", W'(io.busy), W'(m_busy));
    chk("cmp_done", W'(io.done), W'(m_done));
    chk("busy_and_done", W'(io.busy & io.done), '0);
  end

  task automatic set_in(input logic s, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh);
    io.start = s; io.ALUOperation = op; io.A = a; io.B = b; io.shamt = sh;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic single(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp);
    set_in(1'b1, op, a, b, sh);
    cyc();
    chk({name, "_result"}, io.ALUResult, exp);
    chk({name, "_done"}, W'(io.done), 1);
  endtask

  // Issues MULTU/DIVU, optionally pokes an ignored start mid-run, and returns edges until done.
  task automatic multi(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    set_in(1'b1, op, a, b, 5'd0);
    for (int i = 1; i <= 40 && !got; i++) begin
      cyc();
      io.start = 1'b0;
      if (i == 1) chk("multi_busy_rise", W'(io.busy), 1);
      if (poke && i == 3) set_in(1'b1, 4'd3, 32'd1, 32'd1, 5'd0);
      if (io.done) begin got = 1'b1; lat = i; end
    end
  endtask

  initial begin
    int lat;
    set_in(1'b0, 4'd0, '0, '0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", io.ALUResult, 0);
    chk("reset_zero", W'(io.Zero), 1);
    chk("reset_busy", W'(io.busy), 0);
    reset = 1'b0;
    cyc();

    single("add_ovf", 4'd3, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
    chk("add_ovf_flag", W'(io.Overflow), 1);
    single("sub_zero", 4'd4, 32'd5, 32'd5, 5'd0, 32'h0);
    chk("sub_zero_flag", W'(io.Zero), 1);
    chk("sub_ovf_flag", W'(io.Overflow), 0);
    single("sra", 4'd9, 32'h0, 32'h80000000, 5'd4, 32'hF8000000);
    single("lui", 4'd5, 32'h0, 32'h1234, 5'd0, 32'h12340000);
    single("slt_neg", 4'd8, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1);
    single("slt_pos", 4'd8, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0);
    single("code15", 4'd15, 32'h55, 32'h66, 5'd0, 32'h0);
    chk("code15_zero", W'(io.Zero), 1);
    io.start = 1'b0;
    cyc();
    chk("idle_no_done", W'(io.done), 0);

    multi(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
    chk("mul_latency", lat, 33);
    chk("mul_lo", io.ALUResult, 32'h1);
    single("mul_hi", 4'd12, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE);

    multi(4'd11, 32'd100, 32'd7, 1'b0, lat);
    chk("div_latency", lat, 33);
    chk("div_lo", io.ALUResult, 32'd14);
    single("mfhi_div", 4'd12, 32'h0, 32'h0, 5'd0, 32'd2);
    single("mflo_div", 4'd13, 32'h0, 32'h0, 5'd0, 32'd14);

    set_in(1'b1, 4'd11, 32'h1234, 32'h0, 5'd0);
    cyc();
    chk("div0_done", W'(io.done), 1);
    chk("div0_busy", W'(io.busy), 0);
    chk("div0_lo", io.ALUResult, 32'hFFFFFFFF);
    single("div0_hi", 4'd12, 32'h0, 32'h0, 5'd0, 32'h1234);

    set_in(1'b1, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      io.start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", W'(io.busy), 0);
    chk("abort_done", W'(io.done), 0);
    chk("abort_zero", W'(io.Zero), 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("abort_no_done", W'(io.done), 0);
    end
    single("abort_hi", 4'd12, 32'h0, 32'h0, 5'd0, 32'h0);
    single("abort_lo", 4'd13, 32'h0, 32'h0, 5'd0, 32'h0);

    for (int n = 0; n < 600; n++) begin
      logic [3:0] op;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      if ((op == 4'd10 || op == 4'd11) && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 9));
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      set_in($urandom_range(0, 9) < 7, op, W'($urandom), b, 5'($urandom));
      cyc();
    end
    io.start = 1'b0;
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
